rock_ramp_sequencer: RTL and testbench

ROCK_RAMP_SEQUENCER -- requirements
Module: rock_ramp_sequencer

---
 rtl/rock_ramp_sequencer.sv | 170 +++++++++++++++++
 tb/tb_rock_ramp_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rock_ramp_sequencer.sv
// Rock ramp sequencer: moves the rocking amplitude/frequency settings one
// step at a time toward a requested target at a tick-derived rate, dwells at
// the target, supports a ramp-to-zero stop and a latched fault state.
module rock_ramp_sequencer #(
    parameter int STEP_TICKS  = 4,
    parameter int DWELL_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] tgt_amp,
    input  logic [2:0] tgt_freq,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic       stop,
    input  logic       error_in,
    output logic [2:0] amp,
    output logic [2:0] freq,
    output logic       busy,
    output logic       settled,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAMP     = 3'd1,
        DWELL    = 3'd2,
        STOPPING = 3'd3,
        FAULT    = 3'd4
    } state_t;

    localparam logic [7:0] STEP_LAST  = 8'(STEP_TICKS - 1);
    localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);

    state_t     state, next_state;
    logic [2:0] next_amp, next_freq;
    logic [2:0] goal_amp, goal_freq, next_goal_amp, next_goal_freq;
    logic [7:0] tick_cnt, next_tick_cnt;
    logic       next_settled;
    logic       step_due;

    // One unit toward the goal; holds when already there, so no overshoot or wrap.
    function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] goal);
        if (cur < goal)
            return cur + 3'd1;
        else if (cur > goal)
            return cur - 3'd1;
        else
            return cur;
    endfunction

    assign tgt_ready = (state == IDLE) & ~stop & ~error_in;
    assign busy      = (state != IDLE);
    assign fault     = (state == FAULT);
    assign step_due  = tick && (tick_cnt == STEP_LAST);

    // State register and all datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            amp       <= 3'd0;
            freq      <= 3'd0;
            goal_amp  <= 3'd0;
            goal_freq <= 3'd0;
            tick_cnt  <= 8'd0;
            settled   <= 1'b0;
        end else begin
            state     <= next_state;
            amp       <= next_amp;
            freq      <= next_freq;
            goal_amp  <= next_goal_amp;
            goal_freq <= next_goal_freq;
            tick_cnt  <= next_tick_cnt;
            settled   <= next_settled;
        end
    end

    // Next-state and next-register logic; error overrides everything after the case.
    always_comb begin
        next_state     = state;
        next_amp       = amp;
        next_freq      = freq;
        next_goal_amp  = goal_amp;
        next_goal_freq = goal_freq;
        next_tick_cnt  = tick_cnt;
        next_settled   = settled;

        case (state)
            IDLE: begin
                if (stop) begin
                    // Already at zero means nothing to ramp down: stay idle
                    // so a held stop does not bounce between states.
                    next_goal_amp  = 3'd0;
                    next_goal_freq = 3'd0;
                    next_tick_cnt  = 8'd0;
                    next_settled   = 1'b0;
                    if (amp != 3'd0 || freq != 3'd0)
                        next_state = STOPPING;
                end else if (tgt_valid && tgt_ready) begin
                    next_goal_amp  = tgt_amp;
                    next_goal_freq = tgt_freq;
                    next_tick_cnt  = 8'd0;
                    next_settled   = 1'b0;
                    next_state     = RAMP;
                end
            end
            RAMP: begin
                if (stop) begin
                    next_goal_amp  = 3'd0;
                    next_goal_freq = 3'd0;
                    next_tick_cnt  = 8'd0;
                    next_settled   = 1'b0;
                    next_state     = STOPPING;
                end else if (amp == goal_amp && freq == goal_freq) begin
                    next_tick_cnt = 8'd0;
                    next_state    = DWELL;
                end else if (step_due) begin
                    next_amp      = step_toward(amp, goal_amp);
                    next_freq     = step_toward(freq, goal_freq);
                    next_tick_cnt = 8'd0;
                end else if (tick) begin
                    next_tick_cnt = tick_cnt + 8'd1;
                end
            end
            DWELL: begin
                if (stop) begin
                    next_goal_amp  = 3'd0;
                    next_goal_freq = 3'd0;
                    next_tick_cnt  = 8'd0;
                    next_settled   = 1'b0;
                    next_state     = STOPPING;
                end else if (tick) begin
                    if (tick_cnt == DWELL_LAST) begin
                        next_tick_cnt = 8'd0;
                        next_settled  = 1'b1;
                        next_state    = IDLE;
                    end else begin
                        next_tick_cnt = tick_cnt + 8'd1;
                    end
                end
            end
            STOPPING: begin
                if (amp == 3'd0 && freq == 3'd0) begin
                    next_tick_cnt = 8'd0;
                    next_state    = IDLE;
                end else if (step_due) begin
                    next_amp      = step_toward(amp, goal_amp);
                    next_freq     = step_toward(freq, goal_freq);
                    next_tick_cnt = 8'd0;
                end else if (tick) begin
                    next_tick_cnt = tick_cnt + 8'd1;
                end
            end
            FAULT: begin
                next_amp  = 3'd0;
                next_freq = 3'd0;
            end
            default: next_state = IDLE;
        endcase

        if (error_in) begin
            next_state    = FAULT;
            next_amp      = 3'd0;
            next_freq     = 3'd0;
            next_settled  = 1'b0;
            next_tick_cnt = 8'd0;
        end
    end

endmodule

// File: tb/tb_rock_ramp_sequencer.sv
// Directed bench for rock_ramp_sequencer with hand-computed expectations.
module tb_rock_ramp_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] tgt_amp = 3'd0;
    logic [2:0] tgt_freq = 3'd0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic       stop = 1'b0;
    logic       error_in = 1'b0;
    logic [2:0] amp, freq;
    logic       busy, settled, fault;

    int total = 0;
    int bad = 0;

    rock_ramp_sequencer #(.STEP_TICKS(4), .DWELL_TICKS(8)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .tgt_amp(tgt_amp), .tgt_freq(tgt_freq), .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready), .stop(stop), .error_in(error_in),
        .amp(amp), .freq(freq), .busy(busy), .settled(settled), .fault(fault)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; land 1 time unit past the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // n tick pulses, each followed by a quiet cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    task automatic accept(input logic [2:0] a, input logic [2:0] f);
        tgt_amp   = a;
        tgt_freq  = f;
        tgt_valid = 1'b1;
        cyc();
        tgt_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    int exp_amp[5]  = '{1, 2, 3, 3, 3};
    int exp_freq[5] = '{1, 2, 3, 4, 5};

    initial begin
        // Reset state
        cyc();
        cyc();
        chk("rst_amp", amp, 0);
        chk("rst_freq", freq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_settled", settled, 0);
        chk("rst_ready", tgt_ready, 1);
        reset = 1'b1;
        cyc();

        // Ramp up 0/0 -> 3/5
        accept(3'd3, 3'd5);
        chk("up_busy", busy, 1);
        chk("up_ready", tgt_ready, 0);
        ticks(3);
        chk("up_t3_amp", amp, 0);
        for (int s = 0; s < 5; s++) begin
            ticks((s == 0) ? 1 : 4);
            chk($sformatf("up_step%0d_amp", s + 1), amp, exp_amp[s]);
            chk($sformatf("up_step%0d_freq", s + 1), freq, exp_freq[s]);
        end
        ticks(7);
        chk("dwell7_settled", settled, 0);
        chk("dwell7_busy", busy, 1);
        ticks(1);
        chk("dwell8_settled", settled, 1);
        chk("dwell8_busy", busy, 0);

        // Ramp down 3/5 -> 1/5
        accept(3'd1, 3'd5);
        chk("dn_settled_clr", settled, 0);
        ticks(4);
        chk("dn_t4_amp", amp, 2);
        chk("dn_t4_freq", freq, 5);
        ticks(4);
        chk("dn_t8_amp", amp, 1);
        chk("dn_t8_freq", freq, 5);
        ticks(8);
        chk("dn_settled", settled, 1);

        // Stop mid-ramp at 2/2 heading to 6/6
        do_reset();
        accept(3'd6, 3'd6);
        ticks(8);
        chk("stp_pre_amp", amp, 2);
        chk("stp_pre_freq", freq, 2);
        stop = 1'b1;
        cyc();
        chk("stp_busy", busy, 1);
        ticks(4);
        chk("stp_t4_amp", amp, 1);
        chk("stp_t4_freq", freq, 1);
        ticks(4);
        chk("stp_t8_amp", amp, 0);
        chk("stp_t8_freq", freq, 0);
        cyc();
        chk("stp_idle", busy, 0);
        chk("stp_settled", settled, 0);
        chk("stp_ready", tgt_ready, 0);
        cyc();
        cyc();
        chk("stp_hold_idle", busy, 0);
        // tgt_valid with stop: no accept
        tgt_amp   = 3'd5;
        tgt_freq  = 3'd5;
        tgt_valid = 1'b1;
        #1;
        chk("vs_ready", tgt_ready, 0);
        cyc();
        cyc();
        chk("vs_busy", busy, 0);
        tgt_valid = 1'b0;
        cyc();
        stop = 1'b0;
        cyc();
        chk("vs_ready_after", tgt_ready, 1);
        chk("vs_amp", amp, 0);

        // Async reset mid-ramp at 2/3 (0/1 -> 4/6)
        accept(3'd0, 3'd1);
        ticks(4);
        chk("pre_freq1", freq, 1);
        ticks(8);
        chk("pre_settled", settled, 1);
        accept(3'd4, 3'd6);
        ticks(8);
        chk("mid_amp", amp, 2);
        chk("mid_freq", freq, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_amp", amp, 0);
        chk("arst_freq", freq, 0);
        chk("arst_busy", busy, 0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("arst_ready", tgt_ready, 1);
        chk("arst_busy2", busy, 0);

        // Error in DWELL at 4/4
        accept(3'd4, 3'd4);
        ticks(16);
        chk("err_pre_amp", amp, 4);
        cyc();
        chk("err_pre_busy", busy, 1);
        error_in = 1'b1;
        cyc();
        error_in = 1'b0;
        chk("err_amp", amp, 0);
        chk("err_freq", freq, 0);
        chk("err_fault", fault, 1);
        stop      = 1'b1;
        tgt_valid = 1'b1;
        ticks(5);
        stop      = 1'b0;
        tgt_valid = 1'b0;
        ticks(2);
        chk("err_hold_fault", fault, 1);
        chk("err_hold_ready", tgt_ready, 0);
        chk("err_hold_amp", amp, 0);
        reset = 1'b0;
        #1;
        chk("err_rst_fault", fault, 0);
        cyc();
        reset = 1'b1;
        cyc();

        // Simultaneous valid+stop+error in IDLE
        tgt_amp   = 3'd7;
        tgt_freq  = 3'd7;
        tgt_valid = 1'b1;
        stop      = 1'b1;
        error_in  = 1'b1;
        #1;
        chk("sim_ready", tgt_ready, 0);
        cyc();
        tgt_valid = 1'b0;
        stop      = 1'b0;
        error_in  = 1'b0;
        chk("sim_fault", fault, 1);
        ticks(4);
        chk("sim_amp", amp, 0);
        chk("sim_freq", freq, 0);
        do_reset();
        chk("sim_end_fault", fault, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
